// File: rtl/alu_result_fifo.sv
// ---------------------------------------------------------------------------
// AluResultFifo: first-word fall-through FIFO that buffers ALU results
// ({result, carry, overflow, zero}) between the ALU and a consumer.
//
// Optional feature macro: ALU_STICKY_FLAGS_EN
//   defined   -> sticky_carry / sticky_overflow accumulate the carry and
//                overflow flags of every accepted push; sticky_clr clears them
//                (a setting push in the same cycle as sticky_clr wins).
//   undefined -> sticky outputs are tied to 0 and sticky_clr is ignored.
//
// Parameters
//   DEPTH   entry count, power of two in 2..16
//   DROP_W  width of the saturating drop counter
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   in_valid/in_ready   producer handshake; in_ready depends on state only
//   in_result[3:0], in_carry, in_overflow, in_zero   ALU result fields
//   out_valid/out_ready consumer handshake for the head entry
//   out_result[3:0], out_carry, out_overflow, out_zero  head entry (0 if empty)
//   count               current occupancy
//   drop_count          results offered while full (saturating)
//   sticky_carry, sticky_overflow, sticky_clr   accumulated flags
// ---------------------------------------------------------------------------
module alu_result_fifo #(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_result,
    input  logic                       in_carry,
    input  logic                       in_overflow,
    input  logic                       in_zero,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 out_result,
    output logic                       out_carry,
    output logic                       out_overflow,
    output logic                       out_zero,
    output logic [$clog2(DEPTH):0]     count,
    output logic [DROP_W-1:0]          drop_count,
    output logic                       sticky_carry,
    output logic                       sticky_overflow,
    input  logic                       sticky_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [6:0]        mem_q [DEPTH];
    logic [AW-1:0]     wrPtr_q, wrPtr_d;
    logic [AW-1:0]     rdPtr_q, rdPtr_d;
    logic [AW:0]       count_q, count_d;
    logic [DROP_W-1:0] dropCnt_q, dropCnt_d;

    logic       doPush;
    logic       doPop;
    logic       doDrop;
    logic [6:0] headEntry;

    // Handshake status comes purely from registered occupancy, so in_ready
    // never depends combinationally on out_ready or in_valid.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign doPush    = in_valid & in_ready;
    assign doPop     = out_valid & out_ready;
    assign doDrop    = in_valid & ~in_ready;

    // Unwritten storage must never leak out, so the head is masked when empty.
    assign headEntry = mem_q[rdPtr_q];
    assign {out_result, out_carry, out_overflow, out_zero} = out_valid ? headEntry : 7'd0;

    assign count      = count_q;
    assign drop_count = dropCnt_q;

    // Next-state for pointers, occupancy and the saturating drop counter.
    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        count_d   = count_q;
        dropCnt_d = dropCnt_q;
        if (doPush) wrPtr_d = wrPtr_q + 1'b1;
        if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
        case ({doPush, doPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (doDrop && (dropCnt_q != '1)) dropCnt_d = dropCnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            dropCnt_q <= '0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            dropCnt_q <= dropCnt_d;
        end
    end

    // Storage is not reset; writes are suppressed during reset so a push
    // presented in the reset cycle leaves no trace.
    always_ff @(posedge clk) begin
        if (doPush && !rst) begin
            mem_q[wrPtr_q] <= {in_result, in_carry, in_overflow, in_zero};
        end
    end

`ifdef ALU_STICKY_FLAGS_EN
    logic stickyCarry_q, stickyCarry_d;
    logic stickyOvf_q, stickyOvf_d;

    // Clear first, then set, so a new flag event beats a simultaneous clear.
    always_comb begin
        stickyCarry_d = (stickyCarry_q & ~sticky_clr) | (doPush & in_carry);
        stickyOvf_d   = (stickyOvf_q & ~sticky_clr) | (doPush & in_overflow);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stickyCarry_q <= 1'b0;
            stickyOvf_q   <= 1'b0;
        end else begin
            stickyCarry_q <= stickyCarry_d;
            stickyOvf_q   <= stickyOvf_d;
        end
    end

    assign sticky_carry    = stickyCarry_q;
    assign sticky_overflow = stickyOvf_q;
`else
    logic unusedStickyClr;
    assign unusedStickyClr = sticky_clr;
    assign sticky_carry    = 1'b0;
    assign sticky_overflow = 1'b0;
`endif

endmodule
